// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Turns a raw, bouncing, active-low push-button into a clean key level plus
//   single-cycle press / release / long-press / auto-repeat pulses.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles before key_clean follows
//   LONG_CYCLES      cycles key_clean must stay low before long_pulse
//   REPEAT_CYCLES    period of repeat_pulse once the long press is reached
//
// Ports
//   clk            system clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   key_raw        raw button, asynchronous, 0 = pressed
//   key_clean      debounced level, 0 = pressed
//   press_pulse    1-cycle pulse in the first cycle key_clean is 0
//   release_pulse  1-cycle pulse in the first cycle key_clean is 1
//   long_pulse     1-cycle pulse LONG_CYCLES after press_pulse
//   repeat_pulse   1-cycle pulse every REPEAT_CYCLES after long_pulse
//   long_active    high from long_pulse until release
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_clean,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic long_active
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic              s1_r;
  logic              s2_r;
  logic [DB_W-1:0]   db_cnt_r;
  logic              diff_s;
  logic              expire_s;
  logic              fall_s;
  logic              rise_s;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r;
  logic [HOLD_W-1:0] hold_cnt_nxt_s;
  logic [REP_W-1:0]  rep_cnt_r;
  logic [REP_W-1:0]  rep_cnt_nxt_s;
  logic              long_nxt_s;
  logic              repeat_nxt_s;
  logic              active_nxt_s;

  // Two-stage synchronizer; idles high so reset looks like a released key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
    end else begin
      s1_r <= key_raw;
      s2_r <= s1_r;
    end
  end

  // The clean level flips on the DEBOUNCE_CYCLES-th consecutive disagreement;
  // fall/rise are the edges on which that flip happens.
  assign diff_s   = (s2_r != key_clean);
  assign expire_s = diff_s && (db_cnt_r == DB_LAST);
  assign fall_s   = expire_s && !s2_r;
  assign rise_s   = expire_s && s2_r;

  // Debounce counter, clean level and the press/release edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r      <= {DB_W{1'b0}};
      key_clean     <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= fall_s;
      release_pulse <= rise_s;
      if (!diff_s) begin
        db_cnt_r <= {DB_W{1'b0}};
      end else if (expire_s) begin
        db_cnt_r  <= {DB_W{1'b0}};
        key_clean <= s2_r;
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1);
      end
    end
  end

  // Hold-tracking state, counters and registered long/repeat outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      hold_cnt_r   <= {HOLD_W{1'b0}};
      rep_cnt_r    <= {REP_W{1'b0}};
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      long_active  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      hold_cnt_r   <= hold_cnt_nxt_s;
      rep_cnt_r    <= rep_cnt_nxt_s;
      long_pulse   <= long_nxt_s;
      repeat_pulse <= repeat_nxt_s;
      long_active  <= active_nxt_s;
    end
  end

  // Next-state logic; a release takes priority over any expiry on the same edge.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    rep_cnt_nxt_s  = rep_cnt_r;
    long_nxt_s     = 1'b0;
    repeat_nxt_s   = 1'b0;
    active_nxt_s   = long_active;
    if (rise_s) begin
      state_nxt_s    = IDLE;
      hold_cnt_nxt_s = {HOLD_W{1'b0}};
      rep_cnt_nxt_s  = {REP_W{1'b0}};
      active_nxt_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          hold_cnt_nxt_s = {HOLD_W{1'b0}};
          rep_cnt_nxt_s  = {REP_W{1'b0}};
          if (fall_s) begin
            state_nxt_s = PRESS;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        PRESS: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_nxt_s    = REPEAT;
            hold_cnt_nxt_s = {HOLD_W{1'b0}};
            rep_cnt_nxt_s  = {REP_W{1'b0}};
            long_nxt_s     = 1'b1;
            active_nxt_s   = 1'b1;
          end else begin
            hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
          end
        end
        REPEAT: begin
          if (rep_cnt_r == REP_LAST) begin
            rep_cnt_nxt_s = {REP_W{1'b0}};
            repeat_nxt_s  = 1'b1;
          end else begin
            rep_cnt_nxt_s = rep_cnt_r + REP_W'(1);
          end
        end
        default: begin
          state_nxt_s    = IDLE;
          hold_cnt_nxt_s = {HOLD_W{1'b0}};
          rep_cnt_nxt_s  = {REP_W{1'b0}};
          active_nxt_s   = 1'b0;
        end
      endcase
    end
  end

endmodule
